data_sram_responder: RTL and testbench
======================================

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock shared with the CPU.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_sram_we  input  1  write strobe from the CPU data port.
REQ-005 data_sram_addr  input  32  byte address from the CPU; bits [1:0] are ignored.
REQ-006 data_sram_wdata  input  32  write data.
REQ-007 data_sram_rdata  output  32  read data, combinational from the current address.
REQ-008 console_data  output  8  byte at the console FIFO head.
REQ-009 console_valid  output  1  high when the FIFO is non-empty.
REQ-010 console_ready  input  1  sink accepts the byte; a pop occurs when console_valid and console_ready are both high at a rising edge.

Function
REQ-011 SHALL decode addresses as MMIO when addr[31:16]==16'hBFAF; all other addresses SHALL map to RAM word addr[11:2].
REQ-012 RAM SHALL be 1024 x 32 bits, with a synchronous write on a rising edge when we is high and an asynchronous (same-cycle) read.
REQ-013 A RAM read of a word written at edge N SHALL return the new data from cycle N+1 onward.
REQ-014 MMIO 0xBFAFF000 TIMER: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0; a write SHALL make the value after that edge equal wdata (no increment that cycle).
REQ-015 MMIO 0xBFAFF004 CONSOLE_DATA: a write pushes wdata[7:0]; reads return 0.
REQ-016 MMIO 0xBFAFF008 CONSOLE_STATUS read: bit0 full, bit1 empty, bits[4:2] count (0..4), bit5 overflow, all other bits 0.
REQ-017 A STATUS write with wdata[5]=1 SHALL clear overflow; other STATUS write bits SHALL be ignored.
REQ-018 Unmapped MMIO offsets SHALL read 0, and writes to them SHALL be ignored.
REQ-019 Console FIFO SHALL be 4 entries deep, first-in first-out, with console_data driven from the head entry.
REQ-020 A push SHALL be accepted if count<4, or if count==4 and a pop occurs in the same cycle (count unchanged).
REQ-021 A push that is not accepted SHALL be dropped and SHALL set overflow (sticky).
REQ-022 A simultaneous push and pop at count 1..3 SHALL leave count unchanged and preserve order.
REQ-023 A pop when empty is impossible, because console_valid is 0.
REQ-024 Read pointers and write pointers SHALL be 2 bits and wrap modulo 4.
REQ-025 data_sram_rdata SHALL have no read side effects.

Reset
REQ-026 On reset assertion, immediately: TIMER=0, FIFO count=0, pointers=0, overflow=0, console_valid=0.
REQ-027 While reset is high, writes SHALL be ignored and the TIMER SHALL hold at 0.
REQ-028 RAM contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-drain SHALL discard all queued bytes.

Configuration
REQ-030 Macro DSRAM_CONSOLE_EN defined: console FIFO and STATUS behave as specified above.
REQ-031 DSRAM_CONSOLE_EN undefined: no FIFO storage; console_valid=0, console_data=0; CONSOLE_DATA writes are ignored; STATUS reads 0x00000002; ports remain present.

Verification
REQ-032 Write 0x12345678 to 0x1C000100, then read the same address next cycle -> rdata=0x12345678; read 0x1C001100 (aliases word 0x040) -> 0x12345678.
REQ-033 Release reset, wait 10 cycles, read TIMER -> 10 (±0 by construction); write 0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on successive cycles.
REQ-034 With console_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x31 (full, count 4, overflow); raise ready -> console_data 0x41,0x42,0x43,0x44 on consecutive cycles, then valid=0, STATUS=0x22; write STATUS 0x20 -> 0x02.
REQ-035 Full FIFO with ready=1, push 0x55 on the same edge -> accepted, no overflow, 0x55 emerges fifth.
REQ-036 Assert reset asynchronously mid-drain with 3 bytes queued -> console_valid falls without a clock edge; after release STATUS=0x02 and RAM data written before reset reads back unchanged.
REQ-037 With DSRAM_CONSOLE_EN undefined, push 0x41 -> console_valid stays 0 and STATUS=0x00000002.

Source files
------------

// File: rtl/data_sram_responder.sv
// CPU data-port responder: 1024x32 RAM, free-running TIMER and a 4-deep console FIFO in MMIO space.
// Define DSRAM_CONSOLE_EN to build the console FIFO; without it the console is stubbed out.
module data_sram_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready
);

    localparam logic [15:0] MMIO_BASE  = 16'hBFAF;
    localparam logic [13:0] OFF_TIMER  = 14'h3C00;
    localparam logic [13:0] OFF_CDATA  = 14'h3C01;
    localparam logic [13:0] OFF_STATUS = 14'h3C02;

    logic        is_mmio;
    logic [13:0] mmio_off;
    logic [9:0]  ram_idx;
    logic        wr_timer;
    logic        wr_cdata;
    logic        wr_status;
    logic        wr_ram;

    assign is_mmio   = (data_sram_addr[31:16] == MMIO_BASE);
    assign mmio_off  = data_sram_addr[15:2];
    assign ram_idx   = data_sram_addr[11:2];
    assign wr_timer  = data_sram_we && is_mmio && (mmio_off == OFF_TIMER);
    assign wr_cdata  = data_sram_we && is_mmio && (mmio_off == OFF_CDATA);
    assign wr_status = data_sram_we && is_mmio && (mmio_off == OFF_STATUS);
    assign wr_ram    = data_sram_we && !is_mmio && !reset;

    // RAM has no reset: contents survive a reset pulse.
    logic [31:0] mem_q [0:1023];

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem_q[ram_idx] <= data_sram_wdata;
        end
    end

    logic [31:0] timer_q;
    logic [31:0] timer_d;

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (wr_timer) begin
            timer_d = data_sram_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

    logic [31:0] status_word;

`ifdef DSRAM_CONSOLE_EN
    logic [7:0] fifo_q [0:3];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       pop;
    logic       push_ok;

    assign pop     = (count_q != 3'd0) && console_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok = wr_cdata && ((count_q != 3'd4) || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {1'b0, push_ok};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        count_d  = count_q;
        ovf_d    = ovf_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (wr_status && data_sram_wdata[5]) begin
            ovf_d = 1'b0;
        end
        if (wr_cdata && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            fifo_q[wr_ptr_q] <= data_sram_wdata[7:0];
        end
    end

    assign console_valid = (count_q != 3'd0);
    assign console_data  = fifo_q[rd_ptr_q];
    assign status_word   = {26'd0, ovf_q, count_q, (count_q == 3'd0), (count_q == 3'd4)};

    logic unused_bits;
    assign unused_bits = ^data_sram_addr[1:0];
`else
    assign console_valid = 1'b0;
    assign console_data  = 8'd0;
    assign status_word   = 32'h0000_0002;

    logic unused_bits;
    assign unused_bits = ^{data_sram_addr[1:0], console_ready, wr_cdata, wr_status};
`endif

    // Pure decode of the current address; reads never change state.
    always_comb begin
        data_sram_rdata = 32'd0;
        if (is_mmio) begin
            case (mmio_off)
                OFF_TIMER:  data_sram_rdata = timer_q;
                OFF_STATUS: data_sram_rdata = status_word;
                default:    data_sram_rdata = 32'd0;
            endcase
        end else begin
            data_sram_rdata = mem_q[ram_idx];
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized and directed bench for data_sram_responder against a queue/array reference model.
// Console expectations follow whether DSRAM_CONSOLE_EN is defined.
module tb_data_sram_responder;

    localparam logic [31:0] A_TIMER  = 32'hBFAF_F000;
    localparam logic [31:0] A_CDATA  = 32'hBFAF_F004;
    localparam logic [31:0] A_STATUS = 32'hBFAF_F008;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  cdata;
    logic        cvalid;
    logic        cready;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .console_data    (cdata),
        .console_valid   (cvalid),
        .console_ready   (cready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [31:0] ram_m [1024];
    bit          ram_k [1024];
    logic [31:0] timer_m;
    logic [7:0]  q_m [$];
    bit          ovf_m;

    logic [31:0] last_rdata;
    logic [7:0]  last_cdata;
    logic        last_valid;

    function automatic bit is_reg(input logic [31:0] a, input logic [15:0] off);
        return (a[31:16] == 16'hBFAF) && ({a[15:2], 2'b00} == off);
    endfunction

    function automatic logic [31:0] model_status();
        int sz;
        sz = q_m.size();
`ifdef DSRAM_CONSOLE_EN
        return 32'(ovf_m * 32 + sz * 4 + ((sz == 0) ? 2 : 0) + ((sz == 4) ? 1 : 0));
`else
        return 32'(sz + 2);
`endif
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a[31:16] == 16'hBFAF) begin
            if (is_reg(a, 16'hF000)) return timer_m;
            if (is_reg(a, 16'hF008)) return model_status();
            return 32'd0;
        end
        return ram_m[a[11:2]];
    endfunction

    task automatic model_reset();
        timer_m = 32'd0;
        q_m.delete();
        ovf_m = 1'b0;
    endtask

    // Applies the effect of one rising edge using the inputs held across it.
    task automatic model_edge();
        int  sz;
        bit  pop;
        if (reset) return;
        if (we && is_reg(addr, 16'hF000)) timer_m = wdata;
        else timer_m = timer_m + 32'd1;
        if (we && addr[31:16] != 16'hBFAF) begin
            ram_m[addr[11:2]] = wdata;
            ram_k[addr[11:2]] = 1'b1;
        end
`ifdef DSRAM_CONSOLE_EN
        sz  = q_m.size();
        pop = cready && (sz > 0);
        if (pop) void'(q_m.pop_front());
        if (we && is_reg(addr, 16'hF004)) begin
            if (sz < 4 || pop) q_m.push_back(wdata[7:0]);
            else ovf_m = 1'b1;
        end
        if (we && is_reg(addr, 16'hF008) && wdata[5]) ovf_m = 1'b0;
`else
        sz  = 0;
        pop = 1'b0;
`endif
    endtask

    // One bus cycle: drive, check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        we = w; addr = a; wdata = d; cready = r;
        @(negedge clk);
        last_rdata = rdata;
        last_cdata = cdata;
        last_valid = cvalid;
        if (a[31:16] == 16'hBFAF || ram_k[a[11:2]]) check_eq("rdata", rdata, model_rd(a));
`ifdef DSRAM_CONSOLE_EN
        check_eq("valid", {31'd0, cvalid}, {31'd0, q_m.size() > 0});
        if (q_m.size() > 0) check_eq("cdata", {24'd0, cdata}, {24'd0, q_m[0]});
`else
        check_eq("valid", {31'd0, cvalid}, 32'd0);
        check_eq("cdata", {24'd0, cdata}, 32'd0);
`endif
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("async_valid", {31'd0, cvalid}, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0: a = A_TIMER;
            1: a = A_CDATA;
            2: a = A_STATUS;
            3: a = {16'hBFAF, 16'(16'hF00C + 4 * $urandom_range(0, 8))};
            default: begin
                a = $urandom & 32'h0FFF_FFFF;
                a[11:2] = 10'($urandom_range(0, 31));
            end
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        reset = 1'b1; we = 1'b0; addr = A_TIMER; wdata = 32'd0; cready = 1'b0;
        model_reset();
        #1;
        check_eq("rst_timer", rdata, 32'd0);
        check_eq("rst_valid", {31'd0, cvalid}, 32'd0);
        addr = A_STATUS;
        #1;
        check_eq("rst_status", rdata, 32'h2);

        // Writes during reset are ignored and TIMER holds 0.
        cycle(1'b1, A_TIMER, 32'h55, 1'b0);
        cycle(1'b1, A_CDATA, 32'h77, 1'b0);
        cycle(1'b0, A_TIMER, 32'd0, 1'b0);
        check_eq("rst_hold", last_rdata, 32'd0);
        reset = 1'b0;

        repeat (10) cycle(1'b0, A_TIMER, 32'd0, 1'b0);
        cycle(1'b0, A_TIMER, 32'd0, 1'b0);
        check_eq("timer_10", last_rdata, 32'd10);
        cycle(1'b1, A_TIMER, 32'hFFFF_FFFE, 1'b0);
        cycle(1'b0, A_TIMER, 32'd0, 1'b0);
        check_eq("timer_fffe", last_rdata, 32'hFFFF_FFFE);
        cycle(1'b0, A_TIMER, 32'd0, 1'b0);
        check_eq("timer_ffff", last_rdata, 32'hFFFF_FFFF);
        cycle(1'b0, A_TIMER, 32'd0, 1'b0);
        check_eq("timer_wrap", last_rdata, 32'd0);

        cycle(1'b1, 32'h1C00_0100, 32'h1234_5678, 1'b0);
        cycle(1'b0, 32'h1C00_0100, 32'd0, 1'b0);
        check_eq("ram_rd", last_rdata, 32'h1234_5678);
        cycle(1'b0, 32'h1C00_1100, 32'd0, 1'b0);
        check_eq("ram_alias", last_rdata, 32'h1234_5678);
        cycle(1'b0, 32'hBFAF_F0F0, 32'd0, 1'b0);
        check_eq("unmapped", last_rdata, 32'd0);

        for (int i = 0; i < 5; i++) cycle(1'b1, A_CDATA, 32'h41 + i, 1'b0);
        cycle(1'b0, A_STATUS, 32'd0, 1'b0);
`ifdef DSRAM_CONSOLE_EN
        check_eq("status_full", last_rdata, 32'h31);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, A_STATUS, 32'd0, 1'b1);
            check_eq("drain", {24'd0, last_cdata}, 32'h41 + i);
        end
        cycle(1'b0, A_STATUS, 32'd0, 1'b1);
        check_eq("drained_valid", {31'd0, last_valid}, 32'd0);
        check_eq("status_ovf", last_rdata, 32'h22);
        cycle(1'b1, A_STATUS, 32'h20, 1'b1);
        cycle(1'b0, A_STATUS, 32'd0, 1'b1);
        check_eq("ovf_clear", last_rdata, 32'h02);

        for (int i = 0; i < 4; i++) cycle(1'b1, A_CDATA, 32'h51 + i, 1'b0);
        cycle(1'b1, A_CDATA, 32'h55, 1'b1);
        cycle(1'b0, A_STATUS, 32'd0, 1'b0);
        check_eq("full_push_pop", last_rdata, 32'h11);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, A_STATUS, 32'd0, 1'b1);
            check_eq("fifth", {24'd0, last_cdata}, 32'h52 + i);
        end
`else
        check_eq("stub_status", last_rdata, 32'h02);
        check_eq("stub_valid", {31'd0, last_valid}, 32'd0);
`endif

        cycle(1'b1, 32'h1C00_0200, 32'hCAFE_F00D, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, A_CDATA, 32'h61 + i, 1'b0);
        cycle(1'b0, A_STATUS, 32'd0, 1'b1);
        async_reset_pulse();
        cycle(1'b1, 32'h1C00_0200, 32'hDEAD_BEEF, 1'b0);
        reset = 1'b0;
        cycle(1'b0, A_STATUS, 32'd0, 1'b0);
        check_eq("post_rst_status", last_rdata, 32'h02);
        cycle(1'b0, 32'h1C00_0200, 32'd0, 1'b0);
        check_eq("ram_kept", last_rdata, 32'hCAFE_F00D);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 2) == 0), rand_addr(), $urandom, ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
